uart_bus_bridge: RTL and testbench

Serial-to-bus debug bridge. Consumes the byte stream from uart_receiver and decodes host commands. Acts as an initiator on an ibex-style data bus, issuing single 32-bit reads and writes. Returns status and read data as bytes through uart_transmitter, so the host can load memory and peek or poke peripherals without the core.

---
 rtl/uart_bus_bridge.sv | 233 +++++++++++++++++++++++
 tb/tb_uart_bus_bridge.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_bus_bridge.sv
// uart_bus_bridge: serial-to-bus debug bridge.
// Decodes host command frames arriving byte by byte from a UART receiver,
// issues one 32-bit read or write on an ibex-style data bus, and returns a
// status byte (plus read data, LSB first) through a UART transmitter.
//   Frames (multi-byte fields LSB first):
//     write: CMD_WRITE A0 A1 A2 A3 D0 D1 D2 D3   -> 'K' or 'E'
//     read : CMD_READ  A0 A1 A2 A3               -> 'K' R0 R1 R2 R3, or 'E'
//     other opcode                               -> '?'
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   rx_data, rx_data_valid         received byte + one-cycle strobe
//   tx_data, tx_data_valid,tx_busy byte to transmitter, one-cycle strobe, busy
//   bus_req/gnt/rvalid/err         bus handshake (single outstanding access)
//   bus_we/be/addr/wdata/rdata     bus request fields and read data
//   busy                           high whenever the bridge is not idle
module uart_bus_bridge #(
  parameter int          TIMEOUT_CYCLES = 1000000,
  parameter logic [7:0]  CMD_WRITE      = 8'h57,
  parameter logic [7:0]  CMD_READ       = 8'h52
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_data_valid,
  output logic [7:0]  tx_data,
  output logic        tx_data_valid,
  input  logic        tx_busy,
  output logic        bus_req,
  input  logic        bus_gnt,
  input  logic        bus_rvalid,
  input  logic        bus_err,
  output logic        bus_we,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  output logic        busy
);

  typedef enum logic [2:0] {
    ST_IDLE          = 3'd0,
    ST_GET_ADDR      = 3'd1,
    ST_GET_DATA      = 3'd2,
    ST_BUS_REQ       = 3'd3,
    ST_BUS_WAIT      = 3'd4,
    ST_TX_LOAD       = 3'd5,
    ST_TX_WAIT_START = 3'd6,
    ST_TX_WAIT_DONE  = 3'd7
  } state_t;

  // Last idle count before abort: abort fires in the TIMEOUT_CYCLES-th idle cycle.
  localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);

  state_t      state_r;
  logic        we_r;
  logic [1:0]  cnt_r;
  logic [31:2] addr_r;       // A0[1:0] is never needed: the bus address is word aligned
  logic [23:0] wdata_r;      // D3 goes straight to bus_wdata when the request launches
  logic [39:0] resp_r;       // response bytes, byte 0 transmitted first
  logic [2:0]  resp_idx_r;
  logic [2:0]  resp_last_r;
  logic [31:0] tmo_r;

  // Command FSM, bus initiator, transmit sequencer and idle timeout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= ST_IDLE;
      we_r          <= 1'b0;
      cnt_r         <= 2'd0;
      addr_r        <= 30'd0;
      wdata_r       <= 24'd0;
      resp_r        <= 40'd0;
      resp_idx_r    <= 3'd0;
      resp_last_r   <= 3'd0;
      tmo_r         <= 32'd0;
      tx_data       <= 8'd0;
      tx_data_valid <= 1'b0;
      bus_req       <= 1'b0;
      bus_we        <= 1'b0;
      bus_be        <= 4'h0;
      bus_addr      <= 32'd0;
      bus_wdata     <= 32'd0;
      busy          <= 1'b0;
    end else begin
      tx_data_valid <= 1'b0;
      if (state_r == ST_IDLE) begin
        tmo_r <= 32'd0;
      end else begin
        tmo_r <= tmo_r + 32'd1;
      end

      // A request that has not been granted must not be withdrawn, so
      // BUS_REQ is exempt from the abort; every later wait can time out.
      if ((state_r != ST_IDLE) && (state_r != ST_BUS_REQ) && (tmo_r == TMO_LAST)) begin
        state_r <= ST_IDLE;
        busy    <= 1'b0;
        bus_req <= 1'b0;
        bus_be  <= 4'h0;
        cnt_r   <= 2'd0;
        tmo_r   <= 32'd0;
      end else begin
        case (state_r)
          ST_IDLE: begin
            if (rx_data_valid) begin
              busy  <= 1'b1;
              cnt_r <= 2'd0;
              tmo_r <= 32'd0;
              if ((rx_data == CMD_WRITE) || (rx_data == CMD_READ)) begin
                we_r    <= (rx_data == CMD_WRITE);
                state_r <= ST_GET_ADDR;
              end else begin
                resp_r      <= {32'd0, 8'h3F};
                resp_idx_r  <= 3'd0;
                resp_last_r <= 3'd0;
                state_r     <= ST_TX_LOAD;
              end
            end
          end

          ST_GET_ADDR: begin
            if (rx_data_valid) begin
              tmo_r <= 32'd0;
              cnt_r <= cnt_r + 2'd1;
              case (cnt_r)
                2'd0:    addr_r[7:2]   <= rx_data[7:2];
                2'd1:    addr_r[15:8]  <= rx_data;
                2'd2:    addr_r[23:16] <= rx_data;
                default: addr_r[31:24] <= rx_data;
              endcase
              if (cnt_r == 2'd3) begin
                if (we_r) begin
                  state_r <= ST_GET_DATA;
                end else begin
                  // A3 is still in flight to addr_r, so take it from rx_data.
                  bus_addr <= {rx_data, addr_r[23:2], 2'b00};
                  bus_we   <= 1'b0;
                  bus_be   <= 4'hF;
                  bus_req  <= 1'b1;
                  state_r  <= ST_BUS_REQ;
                end
              end
            end
          end

          ST_GET_DATA: begin
            if (rx_data_valid) begin
              tmo_r <= 32'd0;
              cnt_r <= cnt_r + 2'd1;
              case (cnt_r)
                2'd0:    wdata_r[7:0]   <= rx_data;
                2'd1:    wdata_r[15:8]  <= rx_data;
                2'd2:    wdata_r[23:16] <= rx_data;
                default: wdata_r        <= wdata_r;
              endcase
              if (cnt_r == 2'd3) begin
                bus_addr  <= {addr_r, 2'b00};
                bus_wdata <= {rx_data, wdata_r};
                bus_we    <= 1'b1;
                bus_be    <= 4'hF;
                bus_req   <= 1'b1;
                state_r   <= ST_BUS_REQ;
              end
            end
          end

          ST_BUS_REQ: begin
            if (bus_gnt) begin
              bus_req <= 1'b0;
              bus_be  <= 4'h0;
              tmo_r   <= 32'd0;
              state_r <= ST_BUS_WAIT;
            end
          end

          ST_BUS_WAIT: begin
            if (bus_rvalid) begin
              tmo_r      <= 32'd0;
              resp_idx_r <= 3'd0;
              if (bus_err) begin
                resp_r      <= {32'd0, 8'h45};
                resp_last_r <= 3'd0;
              end else if (we_r) begin
                resp_r      <= {32'd0, 8'h4B};
                resp_last_r <= 3'd0;
              end else begin
                resp_r      <= {bus_rdata, 8'h4B};
                resp_last_r <= 3'd4;
              end
              state_r <= ST_TX_LOAD;
            end
          end

          ST_TX_LOAD: begin
            if (!tx_busy) begin
              tx_data       <= resp_r[{resp_idx_r, 3'b000} +: 8];
              tx_data_valid <= 1'b1;
              tmo_r         <= 32'd0;
              state_r       <= ST_TX_WAIT_START;
            end
          end

          ST_TX_WAIT_START: begin
            if (tx_busy) begin
              tmo_r   <= 32'd0;
              state_r <= ST_TX_WAIT_DONE;
            end
          end

          ST_TX_WAIT_DONE: begin
            if (!tx_busy) begin
              tmo_r <= 32'd0;
              if (resp_idx_r == resp_last_r) begin
                busy    <= 1'b0;
                state_r <= ST_IDLE;
              end else begin
                resp_idx_r <= resp_idx_r + 3'd1;
                state_r    <= ST_TX_LOAD;
              end
            end
          end

          default: begin
            busy    <= 1'b0;
            bus_req <= 1'b0;
            bus_be  <= 4'h0;
            state_r <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_bus_bridge.sv
// tb_uart_bus_bridge: table-driven bench for uart_bus_bridge.
// A bus responder and a transmitter model run alongside the stimulus; each
// table row is one host frame with its hand-computed bus request and reply.
module tb_uart_bus_bridge;

  logic        clk;
  logic        rst_n;
  logic [7:0]  rx_data;
  logic        rx_data_valid;
  logic [7:0]  tx_data;
  logic        tx_data_valid;
  logic        tx_busy;
  logic        bus_req;
  logic        bus_gnt;
  logic        bus_rvalid;
  logic        bus_err;
  logic        bus_we;
  logic [3:0]  bus_be;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        busy;

  uart_bus_bridge #(.TIMEOUT_CYCLES(50)) dut (
    .clk(clk), .rst_n(rst_n),
    .rx_data(rx_data), .rx_data_valid(rx_data_valid),
    .tx_data(tx_data), .tx_data_valid(tx_data_valid), .tx_busy(tx_busy),
    .bus_req(bus_req), .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid), .bus_err(bus_err),
    .bus_we(bus_we), .bus_be(bus_be), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Responder configuration and observations.
  int          gnt_delay = 0;
  logic        rsp_err = 1'b0;
  logic [31:0] rsp_rdata = 32'd0;
  int          req_seen = 0;
  int          unstable = 0;
  int          req_stuck = 0;
  logic [31:0] cap_addr, cap_wdata;
  logic        cap_we;
  logic [3:0]  cap_be;

  // Transmitter observations.
  logic [7:0]  tx_q[$];
  int          bad_tx = 0;

  typedef struct {
    int          nb;
    logic [71:0] frame;      // byte i at [i*8 +: 8]
    int          gnt_delay;
    logic        err;
    logic [31:0] rdata;
    int          exp_nreq;
    logic [31:0] exp_addr;
    logic        exp_we;
    logic [31:0] exp_wdata;
    int          exp_nresp;
    logic [39:0] exp_resp;   // byte i at [i*8 +: 8]
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string nm, input logic [39:0] act, input logic [39:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // Bus responder: grant after gnt_delay request cycles, then one rvalid.
  initial begin
    bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_err = 1'b0; bus_rdata = 32'd0;
    forever begin
      @(negedge clk);
      if (bus_req) begin
        req_seen++;
        cap_addr = bus_addr; cap_we = bus_we; cap_wdata = bus_wdata; cap_be = bus_be;
        for (int n = 0; bus_req && n < gnt_delay; n++) begin
          @(negedge clk);
          if (bus_req && (bus_addr !== cap_addr || bus_we !== cap_we ||
                          bus_wdata !== cap_wdata || bus_be !== cap_be))
            unstable++;
        end
        if (bus_req) begin
          bus_gnt = 1'b1;
          @(posedge clk); #1 bus_gnt = 1'b0;
          @(negedge clk);
          if (bus_req) req_stuck++;
          bus_rvalid = 1'b1; bus_err = rsp_err; bus_rdata = rsp_rdata;
          @(posedge clk); #1;
          bus_rvalid = 1'b0; bus_err = 1'b0; bus_rdata = 32'd0;
        end
      end
    end
  end

  // Transmitter monitor: log each strobed byte; a strobe while busy is illegal.
  initial begin
    forever begin
      @(negedge clk);
      if (tx_data_valid) begin
        tx_q.push_back(tx_data);
        if (tx_busy) bad_tx++;
      end
    end
  end

  // Transmitter model: busy for 5 cycles starting the cycle after a strobe.
  initial begin
    tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_data_valid) begin
        @(posedge clk); #1 tx_busy = 1'b1;
        repeat (5) @(posedge clk);
        #1 tx_busy = 1'b0;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data = b; rx_data_valid = 1'b1;
    @(negedge clk);
    rx_data_valid = 1'b0; rx_data = 8'h00;
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check({nm, "_idle"}, {39'd0, busy}, 40'd0);
  endtask

  task automatic run_vec(input int id, input vec_t v);
    int r0, u0, s0, b0;
    string nm;
    nm = $sformatf("v%0d", id);
    gnt_delay = v.gnt_delay; rsp_err = v.err; rsp_rdata = v.rdata;
    tx_q.delete();
    r0 = req_seen; u0 = unstable; s0 = req_stuck; b0 = bad_tx;
    for (int i = 0; i < v.nb; i++) send_byte(v.frame[i*8 +: 8]);
    wait_idle(nm);
    check({nm, "_nreq"}, 40'(req_seen - r0), 40'(v.exp_nreq));
    if (v.exp_nreq > 0) begin
      check({nm, "_addr"}, {8'd0, cap_addr}, {8'd0, v.exp_addr});
      check({nm, "_we"}, {39'd0, cap_we}, {39'd0, v.exp_we});
      check({nm, "_be"}, {36'd0, cap_be}, {36'd0, 4'hF});
      check({nm, "_stable"}, 40'(unstable - u0), 40'd0);
      check({nm, "_req_drop"}, 40'(req_stuck - s0), 40'd0);
    end
    if (v.exp_we) check({nm, "_wdata"}, {8'd0, cap_wdata}, {8'd0, v.exp_wdata});
    check({nm, "_ntx"}, 40'(tx_q.size()), 40'(v.exp_nresp));
    for (int i = 0; i < v.exp_nresp; i++) begin
      if (i < tx_q.size())
        check($sformatf("%s_tx%0d", nm, i), {32'd0, tx_q[i]}, {32'd0, v.exp_resp[i*8 +: 8]});
    end
    check({nm, "_tx_overlap"}, 40'(bad_tx - b0), 40'd0);
  endtask

  task automatic check_outputs_zero(input string nm);
    check({nm, "_tx_data"}, {32'd0, tx_data}, 40'd0);
    check({nm, "_tx_valid"}, {39'd0, tx_data_valid}, 40'd0);
    check({nm, "_req"}, {39'd0, bus_req}, 40'd0);
    check({nm, "_we"}, {39'd0, bus_we}, 40'd0);
    check({nm, "_be"}, {36'd0, bus_be}, 40'd0);
    check({nm, "_addr"}, {8'd0, bus_addr}, 40'd0);
    check({nm, "_wdata"}, {8'd0, bus_wdata}, 40'd0);
    check({nm, "_busy"}, {39'd0, busy}, 40'd0);
  endtask

  // Watchdog: the whole run is a few thousand cycles.
  initial begin
    #500000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int r0, n;
    // nb, frame, gnt_delay, err, rdata, exp_nreq, exp_addr, exp_we, exp_wdata, exp_nresp, exp_resp
    vecs[0] = '{9, 72'hDE_AD_BE_EF_00_00_10_00_57, 3, 1'b0, 32'h0000_0000,
                1, 32'h0000_1000, 1'b1, 32'hDEAD_BEEF, 1, 40'h00_0000_004B};
    vecs[1] = '{5, 72'h00_0000_0000_00_20_04_52, 0, 1'b0, 32'h1234_5678,
                1, 32'h0000_2004, 1'b0, 32'h0000_0000, 5, 40'h12_34_56_78_4B};
    vecs[2] = '{5, 72'h00_0000_0080_00_30_03_52, 1, 1'b1, 32'hFFFF_FFFF,
                1, 32'h8000_3000, 1'b0, 32'h0000_0000, 1, 40'h00_0000_0045};
    vecs[3] = '{1, 72'h00_0000_0000_0000_0041, 0, 1'b0, 32'h0000_0000,
                0, 32'h0000_0000, 1'b0, 32'h0000_0000, 1, 40'h00_0000_003F};
    vecs[4] = '{9, 72'h04_03_02_01_FF_FF_FF_FF_57, 2, 1'b1, 32'h0000_0000,
                1, 32'hFFFF_FFFC, 1'b1, 32'h0403_0201, 1, 40'h00_0000_0045};
    vecs[5] = '{5, 72'h00_0000_0000_0000_0052, 0, 1'b0, 32'hA5A5_0FF0,
                1, 32'h0000_0000, 1'b0, 32'h0000_0000, 5, 40'hA5_A5_0F_F0_4B};
    vecs[6] = '{9, 72'h12_34_56_78_40_00_00_08_57, 0, 1'b0, 32'h0000_0000,
                1, 32'h4000_0008, 1'b1, 32'h1234_5678, 1, 40'h00_0000_004B};

    rst_n = 1'b0; rx_data = 8'h00; rx_data_valid = 1'b0;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 5; i++) run_vec(i, vecs[i]);

    // Timeout: a write frame stalls after one address byte.
    tx_q.delete();
    r0 = req_seen;
    send_byte(8'h57);
    send_byte(8'h00);
    repeat (30) @(negedge clk);
    check("tmo_still_busy", {39'd0, busy}, 40'd1);
    repeat (30) @(negedge clk);
    check("tmo_busy", {39'd0, busy}, 40'd0);
    check("tmo_no_req", 40'(req_seen - r0), 40'd0);
    check("tmo_no_tx", 40'(tx_q.size()), 40'd0);
    run_vec(5, vecs[5]);

    // Asynchronous reset while a request waits for grant.
    gnt_delay = 1000;
    send_byte(8'h57);
    send_byte(8'h44); send_byte(8'h33); send_byte(8'h22); send_byte(8'h11);
    send_byte(8'h01); send_byte(8'h00); send_byte(8'h00);
    @(negedge clk); rx_data = 8'h00; rx_data_valid = 1'b1;
    @(negedge clk); rx_data_valid = 1'b0;
    n = 0;
    while (!bus_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("rst_req_seen", {39'd0, bus_req}, 40'd1);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_outputs_zero("rst_mid");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    run_vec(6, vecs[6]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
